// File: rtl/mem_port_ctrl.sv
// Single-port controller sequencing re/we/addr and the shared tri-state data bus of Memory.
// Optional feature: define MEMCTRL_TURNAROUND_EN to insert one bus-turnaround cycle after each write.
module mem_port_ctrl #(
   parameter int DW    = 16,
   parameter int DEPTH = 256,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic          req_write,
   input  logic [AW-1:0] req_addr,
   input  logic [DW-1:0] req_wdata,
   output logic          rsp_valid,
   input  logic          rsp_ready,
   output logic [DW-1:0] rsp_rdata,
   output logic          busy,
   output logic          mem_re,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   inout  logic [DW-1:0] mem_data
);

`ifdef MEMCTRL_TURNAROUND_EN
   typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_RESP, S_TURN} state_t;
`else
   typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ, S_RESP} state_t;
`endif

   state_t        state_q, state_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [DW-1:0] wdata_q, wdata_d;
   logic [DW-1:0] rdata_q, rdata_d;
   logic          req_ready_q, req_ready_d;
   logic          rsp_valid_q, rsp_valid_d;
   logic          busy_q, busy_d;
   logic          mem_re_q, mem_re_d;
   logic          mem_we_q, mem_we_d;
   logic          bus_oe_q, bus_oe_d;

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      unique case (state_q)
         S_IDLE: begin
            if (req_valid && req_ready_q) begin
               addr_d  = req_addr;
               wdata_d = req_wdata;
               state_d = req_write ? S_WRITE : S_READ;
            end
         end
         S_WRITE: begin
`ifdef MEMCTRL_TURNAROUND_EN
            state_d = S_TURN;
`else
            state_d = S_IDLE;
`endif
         end
         S_READ: begin
            // Memory drives the bus combinationally while re is high; sample it on the closing edge.
            rdata_d = mem_data;
            state_d = S_RESP;
         end
         S_RESP: begin
            if (rsp_ready) begin
               state_d = S_IDLE;
            end
         end
`ifdef MEMCTRL_TURNAROUND_EN
         S_TURN: begin
            state_d = S_IDLE;
         end
`endif
         default: state_d = S_IDLE;
      endcase

      // Outputs are decoded from the next state so they are registered alongside it.
      req_ready_d = (state_d == S_IDLE);
      rsp_valid_d = (state_d == S_RESP);
      busy_d      = (state_d != S_IDLE);
      mem_re_d    = (state_d == S_READ);
      mem_we_d    = (state_d == S_WRITE);
      bus_oe_d    = (state_d == S_WRITE);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= S_IDLE;
         addr_q      <= '0;
         wdata_q     <= '0;
         rdata_q     <= '0;
         req_ready_q <= 1'b1;
         rsp_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         mem_re_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         bus_oe_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         rdata_q     <= rdata_d;
         req_ready_q <= req_ready_d;
         rsp_valid_q <= rsp_valid_d;
         busy_q      <= busy_d;
         mem_re_q    <= mem_re_d;
         mem_we_q    <= mem_we_d;
         bus_oe_q    <= bus_oe_d;
      end
   end

   assign req_ready = req_ready_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rdata_q;
   assign busy      = busy_q;
   assign mem_re    = mem_re_q;
   assign mem_addr  = addr_q;

   // Write strobe and bus drive drop in the same cycle reset rises, so a reset cycle never writes.
   assign mem_we   = mem_we_q & ~reset;
   assign mem_data = (bus_oe_q && !reset) ? wdata_q : 'z;

endmodule
